// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared RAM bus widths and the scan-out reader state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_bus_pkg;

  localparam int RAM_ADDR_W = 24;
  localparam int RAM_DATA_W = 32;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

endpackage

// File: rtl/ram_scanout_reader_if.sv
// ram_scanout_reader_if: word-addressed RAM request/ack bus.
// Latency: n/a (wires only); ram_data_in is valid in the ram_ack cycle.
// Backpressure: the master holds ram_stb/ram_addr until the slave pulses ram_ack.
// Ports: master drives ram_stb/ram_we/ram_addr; slave drives ram_data_in/ram_ack.
interface ram_scanout_reader_if;
  import ram_bus_pkg::*;

  logic                  ram_stb;
  logic                  ram_we;
  logic [RAM_ADDR_W+1:2] ram_addr;
  ram_data_t             ram_data_in;
  logic                  ram_ack;

  modport master (
    output ram_stb, ram_we, ram_addr,
    input  ram_data_in, ram_ack
  );

  modport slave (
    input  ram_stb, ram_we, ram_addr,
    output ram_data_in, ram_ack
  );
endinterface

// File: rtl/ram_scanout_fifo.sv
// ram_scanout_fifo: synchronous word buffer with registered occupancy and flush.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees the slot; pop while empty is ignored.
// Ports: clk/rst, flush, push/push_dat, pop, head_dat (combinational head), empty, count.
module ram_scanout_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is the one being written.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ram_scanout_reader.sv
// ram_scanout_reader: fetches WORDS_PER_FRAME consecutive RAM words per frame into a word buffer.
// Latency: first strobe the cycle after frame_start; a word is visible the cycle after its ack.
// Backpressure: no strobe while the buffer is full; at most one request outstanding.
// Ports: clk/rst, frame_start/base_addr, ram (RAM bus master), word_valid/word_data/word_pop,
//        underflow (sticky pop-while-empty), frame_done.
module ram_scanout_reader
  import ram_bus_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 307200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [25:2]          base_addr,
  ram_scanout_reader_if.master ram,
  output logic                 word_valid,
  output logic [31:0]          word_data,
  input  logic                 word_pop,
  output logic                 underflow,
  output logic                 frame_done
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [CNT_W-1:0]  BUF_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] FRAME_LAST = WCNT_W'(WORDS_PER_FRAME);

  scan_state_e       state;
  scan_state_e       state_nxt;
  ram_addr_t         addr_q;
  ram_addr_t         pend_addr;
  ram_addr_t         restart_addr;
  logic [WCNT_W-1:0] word_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              ram_stb_c;
  logic              restart;
  logic              push;
  logic              pend_load;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ram_stb_c    = 1'b0;
    restart      = 1'b0;
    restart_addr = base_addr;
    push         = 1'b0;
    pend_load    = 1'b0;
    frame_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          restart   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Only registered state feeds the strobe; while it is high the count can only
        // fall, so the strobe stays up until the ack.
        ram_stb_c = (fifo_count < BUF_FULL);
        if (ram_stb_c && frame_start && !ram.ram_ack) begin
          pend_load = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (frame_start) begin
          // Covers a restart coinciding with an ack: that word belongs to the old frame.
          restart   = 1'b1;
          state_nxt = ST_REQ;
        end else if (ram_stb_c && ram.ram_ack) begin
          push      = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (frame_start) begin
          restart   = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          state_nxt = (word_cnt == FRAME_LAST) ? ST_DONE : ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Finish the abandoned request, drop its data, then restart at the newest base.
        ram_stb_c = 1'b1;
        if (ram.ram_ack) begin
          restart      = 1'b1;
          restart_addr = frame_start ? base_addr : pend_addr;
          state_nxt    = ST_REQ;
        end else if (frame_start) begin
          pend_load = 1'b1;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        if (frame_start) begin
          restart   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      pend_addr <= '0;
      word_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      if (restart) begin
        addr_q   <= restart_addr;
        word_cnt <= '0;
      end else if (push) begin
        addr_q   <= addr_q + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (pend_load) pend_addr <= base_addr;
      if (frame_start)                 underflow <= 1'b0;
      else if (word_pop && fifo_empty) underflow <= 1'b1;
    end
  end

  assign ram.ram_stb  = ram_stb_c;
  assign ram.ram_we   = 1'b0;
  assign ram.ram_addr = addr_q;
  assign word_valid   = !fifo_empty;

  ram_scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RAM_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (restart),
    .push     (push),
    .push_dat (ram.ram_data_in),
    .pop      (word_pop),
    .head_dat (word_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_ram_scanout_reader.sv
// tb_ram_scanout_reader: two readers (4-word frames and 40-word frames) against RAM responders.
// Latency: n/a.
// Backpressure: the consumer pops at chosen or random cycles.
module tb_ram_scanout_reader;
  import ram_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;
  logic [31:0] salt;

  // reader A: 4-word frames
  logic        fs_a = 1'b0, pop_a = 1'b0;
  logic [25:2] base_a = '0;
  logic        vld_a, uf_a, done_a;
  logic [31:0] dat_a;
  ram_scanout_reader_if bus_a();
  ram_scanout_reader #(.WORDS_PER_FRAME(4), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .base_addr(base_a), .ram(bus_a),
    .word_valid(vld_a), .word_data(dat_a), .word_pop(pop_a), .underflow(uf_a),
    .frame_done(done_a));

  // reader B: 40-word frames
  logic        fs_b = 1'b0, pop_b = 1'b0;
  logic [25:2] base_b = '0;
  logic        vld_b, uf_b, done_b;
  logic [31:0] dat_b;
  ram_scanout_reader_if bus_b();
  ram_scanout_reader #(.WORDS_PER_FRAME(40), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .base_addr(base_b), .ram(bus_b),
    .word_valid(vld_b), .word_data(dat_b), .word_pop(pop_b), .underflow(uf_b),
    .frame_done(done_b));

  function automatic logic [31:0] ram_word(input logic [23:0] a);
    return {a[7:0], a} ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // RAM model A: fixed ack delay, logs acked addresses and stb-low cycles after each ack.
  int          dly_a = 3, hold_a = 0, gcnt_a = 0;
  bit          arm_a = 1'b0;
  logic [23:0] log_a[$];
  int          gap_a[$];
  always @(negedge clk) begin
    if (rst) begin
      bus_a.ram_ack = 1'b0; bus_a.ram_data_in = '0; hold_a = 0; arm_a = 1'b0;
    end else begin
      if (arm_a) begin
        if (bus_a.ram_stb) begin gap_a.push_back(gcnt_a); arm_a = 1'b0; end
        else gcnt_a++;
      end
      if (bus_a.ram_ack) bus_a.ram_ack = 1'b0;
      else if (bus_a.ram_stb) begin
        hold_a++;
        if (hold_a >= dly_a) begin
          bus_a.ram_ack = 1'b1;
          bus_a.ram_data_in = ram_word(bus_a.ram_addr);
          log_a.push_back(bus_a.ram_addr);
          hold_a = 0; arm_a = 1'b1; gcnt_a = 0;
        end
      end else hold_a = 0;
    end
  end

  // RAM model B: fixed or random delay; optional stray acks while no strobe is up.
  int          dly_b = 2, hold_b = 0, rnd_b = 3;
  bit          spur_b = 1'b0;
  logic [23:0] log_b[$];
  always @(negedge clk) begin
    if (rst) begin
      bus_b.ram_ack = 1'b0; bus_b.ram_data_in = '0; hold_b = 0;
    end else if (bus_b.ram_ack) bus_b.ram_ack = 1'b0;
    else if (bus_b.ram_stb) begin
      hold_b++;
      if (hold_b >= ((dly_b != 0) ? dly_b : rnd_b)) begin
        bus_b.ram_ack = 1'b1;
        bus_b.ram_data_in = ram_word(bus_b.ram_addr);
        log_b.push_back(bus_b.ram_addr);
        hold_b = 0;
        rnd_b = int'($urandom_range(1, 5));
      end
    end else begin
      hold_b = 0;
      if (spur_b && ($urandom_range(0, 2) == 32'd0)) begin
        bus_b.ram_ack = 1'b1;
        bus_b.ram_data_in = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic start_a(input logic [23:0] b);
    base_a = b; fs_a = 1'b1; tick(); fs_a = 1'b0;
  endtask

  // clean: wait for a cycle with no request up so the restart is immediate.
  task automatic start_b(input logic [23:0] b, input bit clean);
    if (clean) for (int n = 0; n < 200 && bus_b.ram_stb; n++) tick();
    base_b = b; fs_b = 1'b1; tick(); fs_b = 1'b0;
  endtask

  task automatic pop_word_a(input string tag, input logic [31:0] exp);
    for (int n = 0; n < 50 && !vld_a; n++) tick();
    chk({tag, "_vld"}, 32'(vld_a), 32'd1);
    chk(tag, dat_a, exp);
    pop_a = 1'b1; tick(); pop_a = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int idx, k;
    logic [23:0] rb;
    bit pop;
    salt = $urandom;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_stb", 32'(bus_a.ram_stb), 32'd0);
    chk("rst_we", 32'(bus_a.ram_we), 32'd0);
    chk("rst_addr", 32'(bus_a.ram_addr), 32'd0);
    chk("rst_vld", 32'(vld_a), 32'd0);
    chk("rst_uf", 32'(uf_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);

    // basic 4-word frame, ack 3 cycles after strobe
    dly_a = 3;
    start_a(24'h000100);
    for (int n = 0; n < 200 && !done_a; n++) tick();
    chk("f1_done", 32'(done_a), 32'd1);
    chk("f1_nreq", 32'(log_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_a.size(); i++)
      chk("f1_addr", 32'(log_a[i]), 32'(24'(24'h000100 + i)));
    chk("f1_ngap", 32'(gap_a.size()), 32'd3);
    for (int i = 0; i < 3 && i < gap_a.size(); i++) chk("f1_gap", 32'(gap_a[i]), 32'd1);
    repeat (3) tick();
    chk("f1_idle_stb", 32'(bus_a.ram_stb), 32'd0);
    for (int i = 0; i < 4; i++) pop_word_a("f1_data", ram_word(24'(24'h000100 + i)));
    chk("f1_empty", 32'(vld_a), 32'd0);
    chk("f1_done_hold", 32'(done_a), 32'd1);

    // address wrap
    dly_a = 2;
    idx = log_a.size();
    start_a(24'hFFFFFE);
    for (int n = 0; n < 200 && !done_a; n++) tick();
    chk("wrap_done", 32'(done_a), 32'd1);
    chk("wrap_nreq", 32'(log_a.size() - idx), 32'd4);
    for (int i = 0; i < 4 && idx + i < log_a.size(); i++)
      chk("wrap_addr", 32'(log_a[idx+i]), 32'(24'(24'hFFFFFE + i)));
    for (int i = 0; i < 4; i++) pop_word_a("wrap_data", ram_word(24'(24'hFFFFFE + i)));

    // fill without pops: exactly FIFO_DEPTH requests, then one more per pop
    dly_b = 2;
    idx = log_b.size();
    start_b(24'h002000, 1'b0);
    repeat (150) tick();
    chk("fill_nreq", 32'(log_b.size() - idx), 32'd16);
    chk("fill_stb", 32'(bus_b.ram_stb), 32'd0);
    chk("fill_cnt", 32'(dut_b.fifo_count), 32'd16);
    chk("fill_head", dat_b, ram_word(24'h002000));
    pop_b = 1'b1; tick(); pop_b = 1'b0;
    repeat (30) tick();
    chk("fill_nreq2", 32'(log_b.size() - idx), 32'd17);
    chk("fill_stb2", 32'(bus_b.ram_stb), 32'd0);

    // restart while a request is outstanding
    dly_b = 7;
    idx = log_b.size();
    start_b(24'h004000, 1'b1);
    for (int n = 0; n < 20 && !bus_b.ram_stb; n++) tick();
    tick();
    base_b = 24'h005000; fs_b = 1'b1; tick(); fs_b = 1'b0; base_b = 24'hABCDEF;
    for (int n = 0; n < 12 && log_b.size() == idx; n++) begin
      chk("drain_stb", 32'(bus_b.ram_stb), 32'd1);
      chk("drain_addr", 32'(bus_b.ram_addr), 32'h004000);
      tick();
    end
    tick();
    chk("drain_new_addr", 32'(bus_b.ram_addr), 32'h005000);
    chk("drain_new_stb", 32'(bus_b.ram_stb), 32'd1);
    chk("drain_empty", 32'(vld_b), 32'd0);
    chk("drain_we", 32'(bus_b.ram_we), 32'd0);
    for (int n = 0; n < 40 && !vld_b; n++) tick();
    chk("drain_first", dat_b, ram_word(24'h005000));
    chk("drain_nlog", 32'(log_b.size() - idx), 32'd2);
    if (log_b.size() >= idx + 2) begin
      chk("drain_log0", 32'(log_b[idx]), 32'h004000);
      chk("drain_log1", 32'(log_b[idx+1]), 32'h005000);
    end

    // underflow on pop while empty
    dly_b = 20;
    start_b(24'h006000, 1'b1);
    pop_b = 1'b1; tick(); pop_b = 1'b0;
    chk("uf_set", 32'(uf_b), 32'd1);
    chk("uf_vld", 32'(vld_b), 32'd0);
    chk("uf_cnt", 32'(dut_b.fifo_count), 32'd0);
    for (int n = 0; n < 40 && !vld_b; n++) tick();
    chk("uf_data", dat_b, ram_word(24'h006000));
    chk("uf_sticky", 32'(uf_b), 32'd1);
    start_b(24'h007000, 1'b1);
    chk("uf_clr", 32'(uf_b), 32'd0);

    // push and pop in the same cycle at count 1
    for (int n = 0; n < 40 && !vld_b; n++) tick();
    chk("pp_cnt1", 32'(dut_b.fifo_count), 32'd1);
    chk("pp_head1", dat_b, ram_word(24'h007000));
    for (int n = 0; n < 40 && !bus_b.ram_ack; n++) tick();
    chk("pp_ack", 32'(bus_b.ram_ack), 32'd1);
    pop_b = 1'b1; tick(); pop_b = 1'b0;
    chk("pp_cnt", 32'(dut_b.fifo_count), 32'd1);
    chk("pp_vld", 32'(vld_b), 32'd1);
    chk("pp_head2", dat_b, ram_word(24'h007001));
    pop_b = 1'b1; tick(); pop_b = 1'b0;
    chk("pp_empty", 32'(vld_b), 32'd0);

    // random delays, random pops, stray acks: whole frame in order
    dly_b = 0; spur_b = 1'b1;
    rb = 24'($urandom);
    start_b(rb, 1'b1);
    idx = log_b.size();
    k = 0;
    for (int n = 0; n < 4000 && k < 40; n++) begin
      pop = ($urandom_range(0, 1) == 32'd1);
      if (pop && vld_b) begin
        chk("rnd_data", dat_b, ram_word(24'(rb + k)));
        k++;
      end
      pop_b = pop;
      tick();
    end
    pop_b = 1'b0;
    spur_b = 1'b0;
    tick();
    chk("rnd_words", 32'(k), 32'd40);
    chk("rnd_done", 32'(done_b), 32'd1);
    chk("rnd_vld", 32'(vld_b), 32'd0);
    chk("rnd_nreq", 32'(log_b.size() - idx), 32'd40);
    for (int i = 0; i < 40 && idx + i < log_b.size(); i++)
      chk("rnd_addr", 32'(log_b[idx+i]), 32'(24'(rb + i)));

    // reset mid-request wins over frame_start
    dly_b = 20;
    start_b(24'h000300, 1'b1);
    for (int n = 0; n < 20 && !bus_b.ram_stb; n++) tick();
    rst = 1'b1; fs_b = 1'b1; base_b = 24'h000777;
    tick();
    rst = 1'b0; fs_b = 1'b0;
    tick();
    chk("mrst_stb", 32'(bus_b.ram_stb), 32'd0);
    chk("mrst_addr", 32'(bus_b.ram_addr), 32'd0);
    chk("mrst_vld", 32'(vld_b), 32'd0);
    chk("mrst_done", 32'(done_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_scanout_reader.md
RAM_SCANOUT_READER -- requirements
Module: ram_scanout_reader

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 307200, meaning 32-bit words read per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning word-buffer depth (power of two, at least 4).
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse; restarts reading at base_addr.
REQ-006 SHALL have port base_addr  input  [25:2]  word address of frame start, sampled on frame_start.
REQ-007 SHALL have port ram_stb  output  1  RAM request strobe.
REQ-008 SHALL have port ram_we  output  1  RAM write enable, constant 0.
REQ-009 SHALL have port ram_addr  output  [25:2]  RAM word address.
REQ-010 SHALL have port ram_data_in  input  [31:0]  read data from RAM, valid in the ack cycle.
REQ-011 SHALL have port ram_ack  input  1  one-cycle RAM acknowledge.
REQ-012 SHALL have port word_valid  output  1  buffer non-empty.
REQ-013 SHALL have port word_data  output  [31:0]  head-of-buffer word.
REQ-014 SHALL have port word_pop  input  1  consumer pop request.
REQ-015 SHALL have port underflow  output  1  sticky flag: pop seen while empty.
REQ-016 SHALL have port frame_done  output  1  all words of the frame fetched.

Function
REQ-017 SHALL implement states IDLE, REQ, GAP, DRAIN, DONE.
REQ-018 SHALL, in IDLE on frame_start, latch base_addr into ram_addr, clear the word counter and buffer, clear underflow, and enter REQ on the next cycle.
REQ-019 SHALL, in REQ, assert ram_stb with ram_addr stable only while buffer count < FIFO_DEPTH, which keeps at most one request outstanding.
REQ-020 SHALL, once ram_stb is asserted, hold ram_stb and ram_addr unchanged until ram_ack is sampled high.
REQ-021 SHALL, on ram_ack, push ram_data_in into the buffer in that same cycle, increment ram_addr by 1 and the word counter by 1, deassert ram_stb next cycle, and enter GAP.
REQ-022 SHALL make GAP last exactly one cycle with ram_stb low, then enter REQ, or DONE if the counter equals WORDS_PER_FRAME.
REQ-023 SHALL wrap ram_addr from 24'hFFFFFF to 0 without error.
REQ-024 SHALL, in DONE, assert frame_done, issue no requests, and leave the buffer drainable.
REQ-025 SHALL, on frame_start while a request is outstanding (ram_stb high, no ack yet), enter DRAIN, keep ram_stb and ram_addr held until ack, discard that data, then flush the buffer and behave as in REQ-018.
REQ-026 SHALL, on frame_start in REQ with ram_stb low, GAP, or DONE, act as in REQ-018 immediately.
REQ-027 SHALL, on a simultaneous push and pop, keep the buffer count unchanged and keep data order intact.
REQ-028 SHALL ignore word_pop while empty and set underflow, which stays set until frame_start or rst.
REQ-029 SHALL present word_data combinationally from the buffer head whenever word_valid is 1.
REQ-030 SHALL ignore ram_ack while no request is outstanding.

Reset
REQ-031 SHALL, when rst is high at a clk edge, enter IDLE with ram_stb=0, ram_we=0, ram_addr=0, buffer empty, word_valid=0, underflow=0, frame_done=0, counter=0.
REQ-032 SHALL take rst priority over frame_start and ram_ack in the same cycle.
REQ-033 SHALL not wait for an outstanding ack when reset mid-request; the RAM side has the same reset domain.

Structure
REQ-034 SHALL place the state encoding, RAM_ADDR_W=24 and RAM_DATA_W=32 in shared package ram_bus_pkg.
REQ-035 SHALL implement the buffer as one sub-module, ram_scanout_fifo: synchronous, registered count, flush input.

Verification
REQ-036 SHALL check: rst, frame_start with base_addr=24'h000100, ack 3 cycles after each stb, WORDS_PER_FRAME=4 -> addresses 100,101,102,103; ram_stb low exactly 1 cycle after each ack; frame_done=1 after the 4th ack.
REQ-037 SHALL check: no pops, FIFO_DEPTH=16 -> exactly 16 requests, ram_stb stays low; after one pop, exactly one new request.
REQ-038 SHALL check: frame_start 1 cycle after stb rises, ack 5 cycles later -> stb/addr held until ack, data discarded, next request at the new base_addr, buffer empty.
REQ-039 SHALL check: pop with buffer empty -> underflow=1 and count unchanged; cleared by the next frame_start.
REQ-040 SHALL check: base_addr=24'hFFFFFE, 4 words -> addresses FFFFFE, FFFFFF, 000000, 000001.
REQ-041 SHALL check: push and pop in the same cycle at count 1 -> count stays 1, word_data equals the newly pushed word the next cycle.
